// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants for the pipelined CORDIC engine.
//   ATAN_BAM      : atan(2^-i) as a binary angle with full circle = 2^40, i = 0..31
//   atan_const    : ATAN_BAM[i] rounded to a w-bit binary angle
//   cordic_mode_e : per-sample mode encoding (MODE_ROT / MODE_VEC)
//   CORDIC_K_Q1_30: CORDIC gain K (~1.64676) in Q1.30, for downstream compensation
package cordic_pkg;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } cordic_mode_e;

  localparam int ATAN_BITS    = 40;
  localparam int ATAN_ENTRIES = 32;

  localparam logic [ATAN_BITS-1:0] ATAN_BAM [0:ATAN_ENTRIES-1] = '{
    40'd137438953472, 40'd81134951936,  40'd42869480192,  40'd21761217536,
    40'd10922836750,  40'd5466743128,   40'd2734038625,   40'd1367102738,
    40'd683561799,    40'd341782203,    40'd170891265,    40'd85445653,
    40'd42722829,     40'd21361415,     40'd10680707,     40'd5340354,
    40'd2670177,      40'd1335088,      40'd667544,       40'd333772,
    40'd166886,       40'd83443,        40'd41722,        40'd20861,
    40'd10430,        40'd5215,         40'd2608,         40'd1304,
    40'd652,          40'd326,          40'd163,          40'd81
  };

  localparam logic [31:0] CORDIC_K_Q1_30 = 32'd1768195363;

  // Round-half-up of the 40-bit table entry down to a w-bit angle (w <= 32).
  function automatic logic [31:0] atan_const(input int i, input int w);
    logic [ATAN_BITS-1:0] r;
    r = ATAN_BAM[i] + (40'd1 << (39 - w));
    return 32'(r >> (40 - w));
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one registered CORDIC micro-rotation.
//   clk, rst          : clock, async active-high reset (clears valid and data)
//   en                : pipeline advance; all registers hold when low
//   in_valid, in_mode : slot valid and mode travelling with the data
//   x_in, y_in        : WIDTH+2 signed coordinates
//   z_in              : WIDTH-bit binary angle (wraps modulo 2^WIDTH)
//   out_*             : registered results of this micro-rotation
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter int               SHIFT = 0,
  parameter logic [WIDTH-1:0] ATAN  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic                    in_mode,
  input  logic signed [WIDTH+1:0] x_in,
  input  logic signed [WIDTH+1:0] y_in,
  input  logic        [WIDTH-1:0] z_in,
  output logic                    out_valid,
  output logic                    out_mode,
  output logic signed [WIDTH+1:0] x_out,
  output logic signed [WIDTH+1:0] y_out,
  output logic        [WIDTH-1:0] z_out
);

  logic signed [WIDTH+1:0] x_sh;
  logic signed [WIDTH+1:0] y_sh;
  logic                    d_pos;

  assign x_sh = x_in >>> SHIFT;
  assign y_sh = y_in >>> SHIFT;

  // Rotation drives z toward zero; vectoring drives y toward zero.
  assign d_pos = (in_mode == MODE_VEC) ? y_in[WIDTH+1] : ~z_in[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      if (d_pos) begin
        x_out <= x_in - y_sh;
        y_out <= y_in + x_sh;
        z_out <= z_in - ATAN;
      end else begin
        x_out <= x_in + y_sh;
        y_out <= y_in - x_sh;
        z_out <= z_in + ATAN;
      end
    end
  end

endmodule

// File: rtl/cordic_pipe.sv
// cordic_pipe: fully pipelined CORDIC, rotation or vectoring per sample.
//   clk, rst            : clock, async active-high reset
//   in_valid / in_ready : input handshake; in_ready is the global advance enable
//   in_mode             : 0 = rotation, 1 = vectoring
//   x_in, y_in          : signed WIDTH-bit coordinates
//   z_in                : unsigned binary angle, full circle = 2^WIDTH
//   out_valid/out_ready : output handshake; output holds while stalled
//   out_mode            : mode of the result sample
//   x_out, y_out        : signed WIDTH+2 results, scaled by CORDIC gain K
//   z_out               : residual (rotation) or accumulated (vectoring) angle
// Latency is STAGES+1 cycles: one pre-rotation register plus STAGES stages.
module cordic_pipe
  import cordic_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic        [WIDTH-1:0] x_in,
  input  logic        [WIDTH-1:0] y_in,
  input  logic        [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_mode,
  output logic signed [WIDTH+1:0] x_out,
  output logic signed [WIDTH+1:0] y_out,
  output logic        [WIDTH-1:0] z_out
);

  localparam int XW = WIDTH + 2;
  localparam logic [WIDTH-1:0] HALF_TURN = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 8 || WIDTH > 32) begin : g_bad_width
    $error("cordic_pipe: WIDTH must be in 8..32");
  end
  if (STAGES < 4 || STAGES > WIDTH) begin : g_bad_stages
    $error("cordic_pipe: STAGES must be in 4..WIDTH");
  end

  // One enable for the whole pipe: advance whenever the output slot is free
  // or being consumed. Bubbles advance too, so nothing is collapsed.
  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // ---------------------------------------------------------------------
  // Quadrant pre-rotation: fold the input into the +/-90 degree range the
  // micro-rotations can reach by a 180 degree turn (negate x/y, add half turn).
  // ---------------------------------------------------------------------
  logic signed [XW-1:0] x_ext;
  logic signed [XW-1:0] y_ext;
  logic                 flip;

  assign x_ext = {{2{x_in[WIDTH-1]}}, x_in};
  assign y_ext = {{2{y_in[WIDTH-1]}}, y_in};
  assign flip  = (in_mode == MODE_VEC) ? x_in[WIDTH-1]
                                       : (z_in[WIDTH-1] ^ z_in[WIDTH-2]);

  logic                 pre_valid;
  logic                 pre_mode;
  logic signed [XW-1:0] pre_x;
  logic signed [XW-1:0] pre_y;
  logic [WIDTH-1:0]     pre_z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_valid <= 1'b0;
      pre_mode  <= 1'b0;
      pre_x     <= '0;
      pre_y     <= '0;
      pre_z     <= '0;
    end else if (en) begin
      pre_valid <= in_valid;
      pre_mode  <= in_mode;
      if (flip) begin
        pre_x <= -x_ext;
        pre_y <= -y_ext;
        pre_z <= z_in + HALF_TURN;
      end else begin
        pre_x <= x_ext;
        pre_y <= y_ext;
        pre_z <= z_in;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Micro-rotation chain
  // ---------------------------------------------------------------------
  logic                 v_s [STAGES];
  logic                 m_s [STAGES];
  logic signed [XW-1:0] x_s [STAGES];
  logic signed [XW-1:0] y_s [STAGES];
  logic [WIDTH-1:0]     z_s [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic                 v_i;
    logic                 m_i;
    logic signed [XW-1:0] x_i;
    logic signed [XW-1:0] y_i;
    logic [WIDTH-1:0]     z_i;

    if (i == 0) begin : g_first
      assign v_i = pre_valid;
      assign m_i = pre_mode;
      assign x_i = pre_x;
      assign y_i = pre_y;
      assign z_i = pre_z;
    end else begin : g_chain
      assign v_i = v_s[i-1];
      assign m_i = m_s[i-1];
      assign x_i = x_s[i-1];
      assign y_i = y_s[i-1];
      assign z_i = z_s[i-1];
    end

    cordic_stage #(
      .WIDTH (WIDTH),
      .SHIFT (i),
      .ATAN  (WIDTH'(atan_const(i, WIDTH)))
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (v_i),
      .in_mode   (m_i),
      .x_in      (x_i),
      .y_in      (y_i),
      .z_in      (z_i),
      .out_valid (v_s[i]),
      .out_mode  (m_s[i]),
      .x_out     (x_s[i]),
      .y_out     (y_s[i]),
      .z_out     (z_s[i])
    );
  end

  assign out_valid = v_s[STAGES-1];
  assign out_mode  = m_s[STAGES-1];
  assign x_out     = x_s[STAGES-1];
  assign y_out     = y_s[STAGES-1];
  assign z_out     = z_s[STAGES-1];

endmodule

// File: tb/tb_cordic_pipe.sv
module tb_cordic_pipe;

  localparam int     W      = 16;
  localparam int     S      = 14;
  localparam longint TOL    = S + 2;
  localparam real    PI     = 3.14159265358979323846;
  localparam real    CIRCLE = 65536.0;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic [W-1:0] z_in;
  logic         out_valid;
  logic         out_ready;
  logic         out_mode;
  logic [W+1:0] x_out;
  logic [W+1:0] y_out;
  logic [W-1:0] z_out;

  always #5 clk = ~clk;

  cordic_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out)
  );

  typedef struct {
    logic   mode;
    longint x;
    longint y;
    longint z;
  } exp_t;

  exp_t   sb[$];
  exp_t   cur_exp;
  int     checks = 0;
  int     errors = 0;
  real    k_gain;
  logic   accepted;
  logic   rand_ready = 1'b0;
  logic   hold_pending = 1'b0;
  logic   hm;
  longint hx, hy, hz;

  function automatic longint sx(input logic [W+1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint rnd(input real r);
    if (r >= 0.0) return longint'($rtoi(r + 0.5));
    return -longint'($rtoi(-r + 0.5));
  endfunction

  // Ideal K-scaled result from plain trigonometry.
  function automatic exp_t model(input logic mode, input longint x, input longint y,
                                 input longint z);
    exp_t e;
    real  th, zr;
    e.mode = mode;
    if (mode == 1'b0) begin
      th  = real'(z) * 2.0 * PI / CIRCLE;
      e.x = rnd(k_gain * (real'(x) * $cos(th) - real'(y) * $sin(th)));
      e.y = rnd(k_gain * (real'(x) * $sin(th) + real'(y) * $cos(th)));
      e.z = 0;
    end else begin
      e.x = rnd(k_gain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
      e.y = 0;
      zr  = real'(z) + $atan2(real'(y), real'(x)) * CIRCLE / (2.0 * PI);
      e.z = rnd(zr) & 64'hFFFF;
    end
    return e;
  endfunction

  task automatic chk_eq(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input longint obs, input longint exp);
    checks++;
    assert ((obs - exp <= TOL) && (exp - obs <= TOL)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, exp, TOL);
    end
  endtask

  task automatic chk_ang(input string tag, input longint obs, input longint exp);
    longint d;
    d = (obs - exp) & 64'hFFFF;
    if (d >= 32768) d -= 65536;
    checks++;
    assert ((d <= TOL) && (d >= -TOL)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d +/-%0d (mod 2^16)", tag, obs, exp, TOL);
    end
  endtask

  // One clock: observe just after the falling edge, score, then advance.
  task automatic tick();
    exp_t e;
    #1;
    if (hold_pending) begin
      chk_eq("stall_valid", longint'(out_valid), 1);
      chk_eq("stall_mode", longint'(out_mode), longint'(hm));
      chk_eq("stall_x", sx(x_out), hx);
      chk_eq("stall_y", sx(y_out), hy);
      chk_eq("stall_z", longint'(z_out), hz);
    end
    if (out_valid && out_ready) begin
      chk_eq("unexpected_output", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_eq("out_mode", longint'(out_mode), longint'(e.mode));
        chk_near("x_out", sx(x_out), e.x);
        chk_near("y_out", sx(y_out), e.y);
        chk_ang("z_out", longint'(z_out), e.z);
      end
    end
    hold_pending = out_valid && !out_ready;
    hm = out_mode;
    hx = sx(x_out);
    hy = sx(y_out);
    hz = longint'(z_out);
    accepted = in_valid && in_ready;
    if (accepted) sb.push_back(cur_exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic mode, input longint x, input longint y, input longint z,
                       input exp_t e);
    int n;
    in_valid = 1'b1;
    in_mode  = mode;
    x_in     = W'(x);
    y_in     = W'(y);
    z_in     = W'(z);
    cur_exp  = e;
    n = 0;
    do begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end while (!accepted && n < 200);
    chk_eq("accept_timeout", longint'(accepted), 1);
    in_valid = 1'b0;
  endtask

  task automatic drive_model(input logic mode, input longint x, input longint y,
                             input longint z);
    drive(mode, x, y, z, model(mode, x, y, z));
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk_eq("drain_timeout", longint'(sb.size()), 0);
  endtask

  initial begin
    exp_t   e;
    real    p;
    int     lat;
    longint rx, ry, rz;
    logic   rm;

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0;
    x_in = '0; y_in = '0; z_in = '0; out_ready = 1'b1;
    k_gain = 1.0;
    p = 1.0;
    for (int i = 0; i < S; i++) begin
      k_gain = k_gain * $sqrt(1.0 + p);
      p = p * 0.25;
    end

    // Reset state
    #12;
    chk_eq("rst_out_valid", longint'(out_valid), 0);
    chk_eq("rst_in_ready", longint'(in_ready), 1);
    chk_eq("rst_x_out", sx(x_out), 0);
    chk_eq("rst_z_out", longint'(z_out), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Rotation by 45 degrees, with latency measurement
    in_valid = 1'b1; in_mode = 1'b0;
    x_in = W'(10000); y_in = '0; z_in = 16'h2000;
    e.mode = 1'b0; e.x = 11644; e.y = 11644; e.z = 0;
    cur_exp = e;
    tick();
    chk_eq("first_accept", longint'(accepted), 1);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    chk_eq("latency", lat, S + 1);
    drain();

    // Directed corner cases, back to back
    e.mode = 1'b0; e.x = 0;     e.y = -16468; e.z = 0;
    drive(1'b0, 10000, 0, 16'hC000, e);
    e.mode = 1'b1; e.x = 23289; e.y = 0;      e.z = 16'h2000;
    drive(1'b1, 10000, 10000, 0, e);
    e.mode = 1'b1; e.x = 16468; e.y = 0;      e.z = 16'h8000;
    drive(1'b1, -10000, 0, 0, e);
    e.mode = 1'b1; e.x = 76311; e.y = 0;      e.z = 16'hA000;
    drive(1'b1, -32768, -32768, 0, e);
    drain();

    // Random mixed-mode stream with random backpressure and occasional bubbles
    rand_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      rm = 1'($urandom_range(0, 1));
      rz = longint'($urandom_range(0, 65535));
      do begin
        rx = longint'($urandom_range(0, 32000)) - 16000;
        ry = longint'($urandom_range(0, 32000)) - 16000;
      end while (rm && (rx * rx + ry * ry < 100000000));
      if ($urandom_range(0, 7) == 0) begin
        in_valid = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      drive_model(rm, rx, ry, rz);
    end
    drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;

    // Reset with samples in flight and the output stalled
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) drive_model(1'b1, 12000 + 100 * k, 3000, 0);
    for (int k = 0; k < 14; k++) tick();
    chk_eq("pre_rst_out_valid", longint'(out_valid), 1);
    chk_eq("pre_rst_out_mode", longint'(out_mode), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_eq("arst_out_valid", longint'(out_valid), 0);
    chk_eq("arst_out_mode", longint'(out_mode), 0);
    chk_eq("arst_x_out", sx(x_out), 0);
    chk_eq("arst_y_out", sx(y_out), 0);
    chk_eq("arst_z_out", longint'(z_out), 0);
    chk_eq("arst_in_ready", longint'(in_ready), 1);
    sb.delete();
    hold_pending = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    in_valid = 1'b1; in_mode = 1'b0;
    x_in = W'(-7000); y_in = W'(5000); z_in = 16'h5555;
    cur_exp = model(1'b0, -7000, 5000, 16'h5555);
    tick();
    chk_eq("post_rst_accept", longint'(accepted), 1);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    chk_eq("post_rst_latency", lat, S + 1);
    drain();
    for (int k = 0; k < 20; k++) tick();
    chk_eq("no_stale_out", longint'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_pipe.md
# cordic_pipe

Parametrised, fully pipelined CORDIC engine for the CORDIC datapath. A per-sample mode bit selects rotation (rotate (x,y) by angle z) or vectoring (magnitude and atan2 of (x,y)). Full-circle quadrant pre-rotation is included, so vectoring covers all four quadrants and rotation accepts any angle. It sits between sample sources and downstream magnitude, phase and mixer logic, accepting one sample per cycle under a valid/ready handshake.

## Interface
- `WIDTH`, default 16: signed x/y input width and angle width (binary angle, full circle = 2^WIDTH); legal 8..32.
- `STAGES`, default 14: number of micro-rotation stages; legal 4..WIDTH.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: input sample valid.
- `in_ready` output 1: engine accepts the sample this cycle.
- `in_mode` input 1: 0 = rotation, 1 = vectoring.
- `x_in`, `y_in` input WIDTH: signed two's-complement coordinates.
- `z_in` input WIDTH: angle, unsigned binary angle (0x…0 = 0°, MSB alone = 180°).
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_mode` output 1: mode of the result sample.
- `x_out`, `y_out` output WIDTH+2: signed results, carrying CORDIC gain K≈1.64676 (not compensated).
- `z_out` output WIDTH: residual angle (rotation) or accumulated angle (vectoring).

## Operation
- Internal x/y are WIDTH+2 signed (sign-extended on entry), so K·√2 growth never overflows. z wraps modulo 2^WIDTH by design.
- **Stage 0 (pre-rotation), registered:**
  - Rotation: if z_in[W-1]^z_in[W-2] (angle in 90°..270°), then x=-x_in, y=-y_in, z=z_in+2^(W-1); otherwise pass through.
  - Vectoring: if x_in<0, then x=-x_in, y=-y_in, z=z_in+2^(W-1); otherwise pass through.
- **Stages i=0..STAGES-1, each registered:**
  - Direction: d=+1 if (rotation: z≥0 signed) or (vectoring: y<0), else d=-1.
  - Update: x'=x−d·(y>>>i), y'=y+d·(x>>>i), z'=z−d·ATAN[i].
- ATAN[i] = round(atan(2^-i)/(2π)·2^WIDTH). The mode bit travels with the data.
- Negation of the most-negative input is exact thanks to the 2 guard bits.
- Accuracy: |z error| ≤ STAGES+2 LSB; x/y error ≤ STAGES+2 LSB relative to the exact K-scaled result.

## Timing
- Latency STAGES+1 cycles from accepted input to out_valid, with no bubbles or stalls. Throughput is 1 sample/cycle.
- Global enable `en = out_ready | ~out_valid`; `in_ready = en`.
- When en=0, every stage register (data, mode, valid) holds. Input is accepted iff in_valid & in_ready.
- Output holds stable while out_valid & ~out_ready.
- Bubbles (invalid slots) propagate as valid=0; bubbles are not collapsed.
- Reset (asynchronous, any time, including mid-pipeline):
  - All stage valid bits clear; data registers clear to 0.
  - out_valid=0, out_mode=0, x_out=y_out=z_out=0; in_ready=1 during and after reset.
  - In-flight samples are discarded.
- Simultaneous in_valid with a stalled output: the input is not accepted (in_ready=0), and the source must hold it.

## Structure
- `cordic_pkg`:
  - 40-bit ATAN_BAM table (full circle = 2^40, 32 entries).
  - Function `atan_const(i, W)` that rounds the table to W bits.
  - Mode encodings `MODE_ROT=1'b0`, `MODE_VEC=1'b1`.
  - Gain constant K in Q1.30 for downstream compensation.
- Sub-module `cordic_stage` (parameters WIDTH, SHIFT, ATAN), instantiated STAGES times in a generate loop. Pre-rotation lives in the top.

## Test plan
All with WIDTH=16, STAGES=14.
- Rotation, x=10000, y=0, z=0x2000 (45°) -> after 15 cycles x_out≈11644, y_out≈11644 (±16), z_out≈0 (±16).
- Rotation, x=10000, y=0, z=0xC000 (−90°, exercises pre-rotation) -> x_out≈0, y_out≈−16468 (±16).
- Vectoring, x=10000, y=10000 -> z_out≈0x2000 (±16), x_out≈23289, y_out≈0 (±16). Vectoring, x=−10000, y=0 -> z_out≈0x8000, x_out≈16468.
- Back-to-back stream of 100 random samples of mixed modes -> results match a reference model in order with out_mode preserved; out_ready toggled randomly causes no loss, duplication or data change during stalls.
- Extremes: x_in=−32768, y_in=−32768, vectoring -> x_out≈76311, no overflow, z_out≈0xA000 (225°).
- Assert rst with 5 samples in flight -> outputs and valid clear immediately (asynchronously); after release the first new sample emerges exactly 15 accepted cycles later, with no stale data.
